// File: rtl/mips_core_pkg.sv
// Shared core types: fetched instruction, branch prediction info and the
// instruction queue entry that carries both between fetch and rename.
package mips_core_pkg;

    localparam int INSTRUCTION_QUEUE_DEPTH      = 4;
    localparam int INSTRUCTION_QUEUE_DEPTH_BITS = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } inst;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } branch_pred_info;

    typedef struct packed {
        inst             instruction;
        branch_pred_info pred;
    } iq_entry;

endpackage

// File: rtl/instruction_queue.sv
// Fetch-to-rename decoupling FIFO: circular buffer with occupancy count,
// no empty bypass, no full pass-through, single-cycle flush on recovery.
module instruction_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = INSTRUCTION_QUEUE_DEPTH,
    parameter int DEPTH_BITS = INSTRUCTION_QUEUE_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  inst                   enq_inst,
    input  branch_pred_info       enq_pred,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output inst                   deq_inst,
    output branch_pred_info       deq_pred,
    output logic [DEPTH_BITS:0]   count
);

    localparam logic [DEPTH_BITS:0]   COUNT_FULL = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   COUNT_ONE  = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE    = DEPTH_BITS'(1);

    iq_entry               storage_q [DEPTH];
    logic [DEPTH_BITS-1:0] head_q, head_d;
    logic [DEPTH_BITS-1:0] tail_q, tail_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  enq_fire;
    logic                  deq_fire;

    // Flush gates both handshakes so nothing moves in a recovery cycle.
    always_comb begin
        enq_ready = (count_q != COUNT_FULL) && !flush;
        deq_valid = (count_q != '0) && !flush;
        enq_fire  = enq_valid && enq_ready;
        deq_fire  = deq_valid && deq_ready;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PTR_ONE;
            if (deq_fire) head_d = head_q + PTR_ONE;
            unique case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq_fire) begin
                storage_q[tail_q] <= '{instruction: enq_inst, pred: enq_pred};
            end
        end
    end

    assign deq_inst = storage_q[head_q].instruction;
    assign deq_pred = storage_q[head_q].pred;
    assign count    = count_q;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: fill/drain, full hold, wrap-around,
// flush recovery and asynchronous reset mid-stream.
module tb_instruction_queue;
    import mips_core_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            enq_valid;
    logic            enq_ready;
    inst             enq_inst;
    branch_pred_info enq_pred;
    logic            deq_valid;
    logic            deq_ready;
    inst             deq_inst;
    branch_pred_info deq_pred;
    logic [2:0]      count;

    int n_total = 0;
    int n_bad   = 0;

    instruction_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_inst  (enq_inst),
        .enq_pred  (enq_pred),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_inst  (deq_inst),
        .deq_pred  (deq_pred),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic inst mk_inst(input logic [31:0] pc, input logic [31:0] word);
        inst r;
        r.pc   = pc;
        r.word = word;
        return r;
    endfunction

    function automatic branch_pred_info mk_pred(input logic [31:0] pc);
        branch_pred_info r;
        r.taken  = pc[2];
        r.target = pc + 32'h100;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] word);
        enq_valid = 1'b1;
        enq_inst  = mk_inst(pc, word);
        enq_pred  = mk_pred(pc);
        #1;
        chk("push_ready", enq_ready, 1'b1);
        next_cycle();
        enq_valid = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] word);
        chk({tag, "_valid"}, deq_valid, 1'b1);
        chk({tag, "_inst"}, deq_inst, mk_inst(pc, word));
        chk({tag, "_pred"}, deq_pred, mk_pred(pc));
    endtask

    initial begin
        iq_entry  exp_q[$];
        iq_entry  e;
        int       sent, rcvd, mcount;
        logic     e_fire, d_fire;

        rst_n     = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        enq_inst  = '0;
        enq_pred  = '0;
        #12;
        rst_n = 1'b1;
        #1;
        chk("rst_count", count, 3'd0);
        chk("rst_deq_valid", deq_valid, 1'b0);
        chk("rst_enq_ready", enq_ready, 1'b1);
        chk("rst_deq_inst", deq_inst, 64'h0);
        chk("rst_deq_pred", deq_pred, 64'h0);
        next_cycle();

        // fill four, then drain in order
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 32'h20080001 + 32'(i));
        enq_valid = 1'b1;
        #1;
        chk("full_count", count, 3'd4);
        chk("full_enq_ready", enq_ready, 1'b0);
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_head("drain", 32'h10 + 32'(4 * i), 32'h20080001 + 32'(i));
            next_cycle();
        end
        deq_ready = 1'b0;
        chk("drain_count", count, 3'd0);
        chk("drain_deq_valid", deq_valid, 1'b0);

        // full with enq and deq both held: only deq fires first
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 32'h20080001 + 32'(i));
        enq_valid = 1'b1;
        enq_inst  = mk_inst(32'h50, 32'hDEAD0050);
        enq_pred  = mk_pred(32'h50);
        deq_ready = 1'b1;
        #1;
        chk("hold_enq_ready_full", enq_ready, 1'b0);
        expect_head("hold0", 32'h10, 32'h20080001);
        next_cycle();
        chk("hold_count_3", count, 3'd3);
        chk("hold_enq_ready", enq_ready, 1'b1);
        expect_head("hold1", 32'h14, 32'h20080002);
        next_cycle();
        chk("hold_count_still_3", count, 3'd3);
        enq_valid = 1'b0;
        #1;
        expect_head("hold2", 32'h18, 32'h20080003);
        next_cycle();
        expect_head("hold3", 32'h1C, 32'h20080004);
        next_cycle();
        expect_head("hold4", 32'h50, 32'hDEAD0050);
        next_cycle();
        deq_ready = 1'b0;
        chk("hold_count_end", count, 3'd0);

        // wrap-around stream with deq_ready toggling 1,0,1,...
        sent = 0;
        rcvd = 0;
        mcount = 0;
        for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
            enq_valid = (sent < 10);
            enq_inst  = mk_inst(32'h100 + 32'(4 * sent), 32'hA0000000 + 32'(sent));
            enq_pred  = mk_pred(32'h100 + 32'(4 * sent));
            deq_ready = (cyc % 2 == 0);
            #1;
            e_fire = enq_valid && (mcount < 4);
            d_fire = deq_ready && (mcount > 0);
            chk("wrap_enq_ready", enq_ready, (mcount < 4));
            chk("wrap_deq_valid", deq_valid, (mcount > 0));
            if (d_fire && exp_q.size() > 0) begin
                chk("wrap_inst", deq_inst, exp_q[0].instruction);
                chk("wrap_pred", deq_pred, exp_q[0].pred);
                void'(exp_q.pop_front());
                rcvd++;
            end
            if (e_fire) begin
                e.instruction = enq_inst;
                e.pred        = enq_pred;
                exp_q.push_back(e);
                sent++;
            end
            mcount = mcount + int'(e_fire) - int'(d_fire);
            next_cycle();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        chk("wrap_rcvd", 64'(rcvd), 64'd10);
        chk("wrap_count_end", count, 3'd0);

        // flush with three entries and both handshakes requested
        for (int i = 0; i < 3; i++) push(32'h30 + 32'(4 * i), 32'hB0000000 + 32'(i));
        enq_valid = 1'b1;
        enq_inst  = mk_inst(32'h3C, 32'hB0000003);
        enq_pred  = mk_pred(32'h3C);
        deq_ready = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_deq_valid", deq_valid, 1'b0);
        chk("flush_enq_ready", enq_ready, 1'b0);
        next_cycle();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        chk("flush_count", count, 3'd0);
        chk("flush_deq_valid_after", deq_valid, 1'b0);
        push(32'h40, 32'hC0000040);
        chk("flush_refill_count", count, 3'd1);
        expect_head("flush_refill", 32'h40, 32'hC0000040);

        // async reset mid-stream at count=2
        push(32'h44, 32'hC0000044);
        chk("arst_pre_count", count, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 3'd0);
        chk("arst_deq_valid", deq_valid, 1'b0);
        chk("arst_deq_inst", deq_inst, 64'h0);
        #2;
        rst_n = 1'b1;
        next_cycle();
        chk("arst_post_count", count, 3'd0);
        chk("arst_post_enq_ready", enq_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
